// File: rtl/axi_slv_pkg.sv
// Shared constants and FSM state types for the AXI burst slave.
// AXI_SLV_WRAP_BURST_EN enables WRAP burst support; without it WRAP is refused.
package axi_slv_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  // Burst types this build will actually execute; anything else gets SLVERR per beat.
  function automatic logic burst_supported(input logic [1:0] burst);
`ifdef AXI_SLV_WRAP_BURST_EN
    return (burst != 2'b11);
`else
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
`endif
  endfunction

endpackage

// File: rtl/axi_slv_addr_gen.sv
// Next-beat address for an AXI burst. WRAP math is always computed here; whether
// WRAP is honoured is decided by the slave (AXI_SLV_WRAP_BURST_EN).
module axi_slv_addr_gen
  import axi_slv_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [7:0]  len,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [31:0] step;
  logic [31:0] wrap_mask;

  // FIXED holds, INCR steps by 2^size, WRAP stays inside a (len+1)*2^size aligned window
  always_comb begin
    step      = 32'd1 << size;
    wrap_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = addr + step;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_burst_slave.sv
// AXI burst slave: memory-backed read/write with a write-only byte mailbox.
// Independent read and write FSMs, one burst in flight per direction.
// Optional macro AXI_SLV_WRAP_BURST_EN enables WRAP bursts.
//
// state  | meaning
// R_IDLE | arready high, waiting for an AR handshake
// R_DATA | rvalid high, streaming beats until rlast is accepted
// W_IDLE | awready high, waiting for an AW handshake
// W_DATA | wready high, accepting beats until wlast
// W_RESP | bvalid high, waiting for bready
module axi_burst_slave
  import axi_slv_pkg::*;
#(
  parameter int          TAGW         = 1,
  parameter int          DW           = 64,
  parameter logic [31:0] MEM_BASE     = 32'h0000_0000,
  parameter int          MEM_DEPTH    = 8192,
  parameter logic [31:0] MAILBOX_ADDR = 32'hD058_0000
) (
  input  logic            aclk,
  input  logic            rst,
  input  logic            arvalid,
  output logic            arready,
  input  logic [31:0]     araddr,
  input  logic [TAGW-1:0] arid,
  input  logic [7:0]      arlen,
  input  logic [1:0]      arburst,
  input  logic [2:0]      arsize,
  output logic            rvalid,
  input  logic            rready,
  output logic [DW-1:0]   rdata,
  output logic [1:0]      rresp,
  output logic [TAGW-1:0] rid,
  output logic            rlast,
  input  logic            awvalid,
  output logic            awready,
  input  logic [31:0]     awaddr,
  input  logic [TAGW-1:0] awid,
  input  logic [7:0]      awlen,
  input  logic [1:0]      awburst,
  input  logic [2:0]      awsize,
  input  logic            wvalid,
  output logic            wready,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic            wlast,
  output logic            bvalid,
  input  logic            bready,
  output logic [1:0]      bresp,
  output logic [TAGW-1:0] bid,
  output logic            mbox_valid,
  output logic [7:0]      mbox_data
);

  localparam int          STRBW     = DW / 8;
  localparam int          ADDR_LSB  = $clog2(STRBW);
  localparam int          IDXW      = $clog2(MEM_DEPTH);
  localparam logic [2:0]  SIZE_MAX  = 3'(ADDR_LSB);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * STRBW);

  logic [DW-1:0] mem [MEM_DEPTH];

  // Mailbox wins over memory decode; illegal burst/size is SLVERR regardless of address.
  function automatic logic [1:0] beat_resp(input logic [31:0] addr, input logic [2:0] size,
                                           input logic [1:0] burst);
    logic [31:0] off;
    off = addr - MEM_BASE;
    if (!burst_supported(burst) || (size > SIZE_MAX)) return RESP_SLVERR;
    if (addr == MAILBOX_ADDR) return RESP_OKAY;
    if ((addr >= MEM_BASE) && (off < MEM_BYTES)) return RESP_OKAY;
    return RESP_DECERR;
  endfunction

  function automatic logic [IDXW-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - MEM_BASE;
    return off[ADDR_LSB +: IDXW];
  endfunction

  rd_state_e       r_state, r_state_nxt;
  logic [31:0]     r_addr, r_next;
  logic [7:0]      r_len, r_cnt;
  logic [2:0]      r_size;
  logic [1:0]      r_burst;
  logic [31:0]     rd_addr_sel;
  logic [2:0]      rd_size_sel;
  logic [1:0]      rd_burst_sel, rd_resp_sel;
  logic [DW-1:0]   rd_word;

  wr_state_e       w_state, w_state_nxt;
  logic [31:0]     w_addr, w_next;
  logic [7:0]      w_len, w_cnt;
  logic [2:0]      w_size;
  logic [1:0]      w_burst, w_resp_beat;
  logic            w_beat, w_is_mbox, w_commit;

  axi_slv_addr_gen u_rd_addr_gen (
    .addr(r_addr), .len(r_len), .size(r_size), .burst(r_burst), .next_addr(r_next)
  );

  axi_slv_addr_gen u_wr_addr_gen (
    .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst), .next_addr(w_next)
  );

  // Read and write state registers
  always_ff @(posedge aclk) begin
    if (rst) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_state_nxt;
      w_state <= w_state_nxt;
    end
  end

  // Read FSM next state and channel handshake outputs
  always_comb begin
    r_state_nxt = r_state;
    arready     = 1'b0;
    rvalid      = 1'b0;
    rlast       = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = (r_cnt == r_len);
        if (rready && (r_cnt == r_len)) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Write FSM next state and channel handshake outputs
  always_comb begin
    w_state_nxt = w_state;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && wlast) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Address of the beat about to be launched: the AR address on handshake, else the next burst address
  always_comb begin
    if (r_state == R_IDLE) begin
      rd_addr_sel  = araddr;
      rd_size_sel  = arsize;
      rd_burst_sel = arburst;
    end else begin
      rd_addr_sel  = r_next;
      rd_size_sel  = r_size;
      rd_burst_sel = r_burst;
    end
    rd_resp_sel = beat_resp(rd_addr_sel, rd_size_sel, rd_burst_sel);
    rd_word     = '0;
    if ((rd_resp_sel == RESP_OKAY) && (rd_addr_sel != MAILBOX_ADDR))
      rd_word = mem[word_idx(rd_addr_sel)];
  end

  // Read datapath: rdata/rresp only reload on a launch, so they hold under backpressure
  always_ff @(posedge aclk) begin
    if (rst) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      rid     <= '0;
    end else if ((r_state == R_IDLE) && arvalid) begin
      r_addr  <= araddr;
      r_len   <= arlen;
      r_size  <= arsize;
      r_burst <= arburst;
      r_cnt   <= '0;
      rdata   <= rd_word;
      rresp   <= rd_resp_sel;
      rid     <= arid;
    end else if ((r_state == R_DATA) && rready && (r_cnt != r_len)) begin
      r_addr  <= r_next;
      r_cnt   <= r_cnt + 8'd1;
      rdata   <= rd_word;
      rresp   <= rd_resp_sel;
    end
  end

  assign w_beat      = wvalid && wready;
  assign w_resp_beat = beat_resp(w_addr, w_size, w_burst);
  assign w_is_mbox   = (w_addr == MAILBOX_ADDR);
  assign w_commit    = w_beat && !rst && (w_resp_beat == RESP_OKAY) && !w_is_mbox;

  // Write datapath: burst capture, sticky response (first error wins, wlast mismatch forces SLVERR), mailbox pulse
  always_ff @(posedge aclk) begin
    if (rst) begin
      w_addr     <= '0;
      w_len      <= '0;
      w_size     <= '0;
      w_burst    <= '0;
      w_cnt      <= '0;
      bresp      <= RESP_OKAY;
      bid        <= '0;
      mbox_valid <= 1'b0;
      mbox_data  <= '0;
    end else begin
      mbox_valid <= 1'b0;
      if ((w_state == W_IDLE) && awvalid) begin
        w_addr  <= awaddr;
        w_len   <= awlen;
        w_size  <= awsize;
        w_burst <= awburst;
        w_cnt   <= '0;
        bresp   <= RESP_OKAY;
        bid     <= awid;
      end
      if (w_beat) begin
        w_addr <= w_next;
        w_cnt  <= w_cnt + 8'd1;
        if ((w_resp_beat != RESP_OKAY) && (bresp == RESP_OKAY)) bresp <= w_resp_beat;
        if (wlast != (w_cnt == w_len)) bresp <= RESP_SLVERR;
        if ((w_resp_beat == RESP_OKAY) && w_is_mbox && wstrb[0]) begin
          mbox_valid <= 1'b1;
          mbox_data  <= wdata[7:0];
        end
      end
    end
  end

  // Backing memory has no reset so contents survive a mid-burst reset
  always_ff @(posedge aclk) begin
    if (w_commit) begin
      for (int b = 0; b < STRBW; b++) begin
        if (wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule
